// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one outstanding req/gnt/rvalid access, lane-aligned stores, formatted loads.
// Stalls the pipeline from request until the DONE cycle; read result is registered and changes only on capture.
module mem_stage_lsu #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     MemReadM_i,
  input  logic                     MemWriteM_i,
  input  logic [2:0]               Funct3M_i,
  input  logic [ADDRESS_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]    WriteDataM_i,
  output logic [DATA_WIDTH-1:0]    ReadDataM_o,
  output logic                     StallM_o,
  output logic                     MisalignM_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [3:0]               mem_be_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_fmt;
  logic [DATA_WIDTH-1:0] lane_w;
  logic [1:0]            off;
  logic                  access, bad, pending;

  assign off    = ALUResultM_i[1:0];
  assign access = MemReadM_i | MemWriteM_i;

  always_comb begin
    bad = 1'b0;
    case (Funct3M_i)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = |off;
      default:        bad = 1'b1;
    endcase
  end

  // Everything that could start an access is gated by reset so the pipeline sees no stall in reset.
  assign pending = rst_ni & access & ~bad;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && mem_rvalid_i) rdata_q <= rdata_fmt;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pending) state_d = mem_gnt_i ? (MemWriteM_i ? DONE : WAIT) : REQ;
      REQ:  if (mem_gnt_i) state_d = MemWriteM_i ? DONE : WAIT;
      WAIT: if (mem_rvalid_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = rst_ni & (((state_q == IDLE) & pending) | (state_q == REQ));
    StallM_o    = pending & (state_q != DONE);
    MisalignM_o = rst_ni & access & bad;
    mem_we_o    = MemWriteM_i;
    mem_addr_o  = {ALUResultM_i[ADDRESS_WIDTH-1:2], 2'b00};
    mem_be_o    = 4'b1111;
    mem_wdata_o = WriteDataM_i;
    if (MemWriteM_i) begin
      case (Funct3M_i[1:0])
        2'b00: begin
          mem_be_o    = 4'b0001 << off;
          mem_wdata_o = {4{WriteDataM_i[7:0]}};
        end
        2'b01: begin
          mem_be_o    = 4'b0011 << off;
          mem_wdata_o = {2{WriteDataM_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Bring the addressed lane down to bit 0, then extend by width code.
  assign lane_w = mem_rdata_i >> {off, 3'b000};

  always_comb begin
    case (Funct3M_i)
      3'b000:  rdata_fmt = {{24{lane_w[7]}}, lane_w[7:0]};
      3'b100:  rdata_fmt = {24'b0, lane_w[7:0]};
      3'b001:  rdata_fmt = {{16{lane_w[15]}}, lane_w[15:0]};
      3'b101:  rdata_fmt = {16'b0, lane_w[15:0]};
      default: rdata_fmt = mem_rdata_i;
    endcase
  end

  assign ReadDataM_o = rdata_q;

endmodule
